// File: rtl/bigmul_unit_v2.sv
// bigmul_unit_v2: schoolbook mul/square/mac engine; ports: wr_* operand load, rd_* registered result read, start/n_limbs/mode launch, busy/done/err status, cycles_out busy count
module bigmul_unit_v2 #(
  parameter int LIMB_W = 64,
  parameter int MAX_LIMBS = 64,
  parameter int CNT_W = 64,
  localparam int AW = $clog2(MAX_LIMBS),
  localparam int RW = $clog2(2*MAX_LIMBS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [AW-1:0]     wr_addr,
  input  logic [LIMB_W-1:0] wr_data,
  input  logic [RW-1:0]     rd_addr,
  output logic [LIMB_W-1:0] rd_data,
  input  logic              start,
  input  logic [AW:0]       n_limbs,
  input  logic [1:0]        mode,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  cycles_out
);
  localparam logic [2:0] IDLE = 3'd0, CLEAR = 3'd1, MUL = 3'd2, ROWEND = 3'd3, FIN = 3'd4;
  logic [LIMB_W-1:0] a_mem [MAX_LIMBS];
  logic [LIMB_W-1:0] b_mem [MAX_LIMBS];
  logic [LIMB_W-1:0] r_mem [2*MAX_LIMBS];
  logic [2:0] state_q, state_d;
  logic [AW:0] n_q, n_d, i_q, i_d, j_q, j_d;
  logic [RW-1:0] k_q, k_d;
  logic [1:0] mode_q, mode_d;
  logic [LIMB_W-1:0] carry_q, carry_d, rd_data_q;
  logic pend_q, pend_d, err_q, err_d;
  logic [CNT_W-1:0] count_q, count_d, cycles_q, cycles_d;
  logic r_we;
  logic [RW-1:0] r_wa, mul_a, row_a, clr_last;
  logic [LIMB_W-1:0] r_wd, a_i, b_j;
  logic [2*LIMB_W-1:0] acc;
  logic [LIMB_W:0] s;
  logic legal, last_j, last_i;
  assign busy = (state_q == CLEAR) || (state_q == MUL) || (state_q == ROWEND);
  assign done = state_q == FIN;
  assign err = done && err_q;
  assign rd_data = rd_data_q;
  assign cycles_out = cycles_q;
  assign legal = (n_limbs != '0) && (n_limbs <= (AW+1)'(MAX_LIMBS)) && (mode != 2'b11);
  assign mul_a = RW'(i_q + j_q);
  assign row_a = RW'(i_q + n_q);
  assign clr_last = RW'({n_q, 1'b0} - 1'b1);
  assign a_i = a_mem[i_q[AW-1:0]];
  assign b_j = mode_q == 2'b01 ? a_mem[j_q[AW-1:0]] : b_mem[j_q[AW-1:0]];
  assign acc = (2*LIMB_W)'(r_mem[mul_a]) + (2*LIMB_W)'(a_i) * (2*LIMB_W)'(b_j) + (2*LIMB_W)'(carry_q);
  assign s = (LIMB_W+1)'(r_mem[row_a]) + (LIMB_W+1)'(carry_q) + (LIMB_W+1)'(pend_q);
  assign last_j = j_q == n_q - 1'b1;
  assign last_i = i_q == n_q - 1'b1;
  always_comb begin
    state_d = state_q;
    n_d = n_q;
    mode_d = mode_q;
    i_d = i_q;
    j_d = j_q;
    k_d = k_q;
    carry_d = carry_q;
    pend_d = pend_q;
    err_d = err_q;
    count_d = count_q;
    cycles_d = cycles_q;
    r_we = 1'b0;
    r_wa = mul_a;
    r_wd = acc[LIMB_W-1:0];
    case (state_q)
      IDLE: if (start) begin
        if (legal) begin
          n_d = n_limbs;
          mode_d = mode;
          i_d = '0;
          j_d = '0;
          k_d = '0;
          carry_d = '0;
          pend_d = 1'b0;
          err_d = 1'b0;
          count_d = '0;
          state_d = mode == 2'b10 ? MUL : CLEAR;
        end else begin
          err_d = 1'b1;
          cycles_d = '0;
          state_d = FIN;
        end
      end
      CLEAR: begin
        r_we = 1'b1;
        r_wa = k_q;
        r_wd = '0;
        k_d = k_q + 1'b1;
        count_d = count_q + 1'b1;
        state_d = k_q == clr_last ? MUL : CLEAR;
      end
      MUL: begin
        r_we = 1'b1;
        carry_d = acc[2*LIMB_W-1:LIMB_W];
        count_d = count_q + 1'b1;
        j_d = last_j ? '0 : j_q + 1'b1;
        state_d = last_j ? ROWEND : MUL;
      end
      ROWEND: begin
        r_we = 1'b1;
        r_wa = row_a;
        r_wd = s[LIMB_W-1:0];
        pend_d = s[LIMB_W];
        carry_d = '0;
        count_d = count_q + 1'b1;
        i_d = last_i ? i_q : i_q + 1'b1;
        cycles_d = last_i ? count_q + 1'b1 : cycles_q;
        state_d = last_i ? FIN : MUL;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      n_q <= '0;
      mode_q <= '0;
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
      carry_q <= '0;
      pend_q <= 1'b0;
      err_q <= 1'b0;
      count_q <= '0;
      cycles_q <= '0;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      mode_q <= mode_d;
      i_q <= i_d;
      j_q <= j_d;
      k_q <= k_d;
      carry_q <= carry_d;
      pend_q <= pend_d;
      err_q <= err_d;
      count_q <= count_d;
      cycles_q <= cycles_d;
      rd_data_q <= r_mem[rd_addr];
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en && !busy && !wr_sel) a_mem[wr_addr] <= wr_data;
    if (wr_en && !busy && wr_sel) b_mem[wr_addr] <= wr_data;
    if (r_we) r_mem[r_wa] <= r_wd;
  end
endmodule

// File: tb/tb_bigmul_unit_v2.sv
// tb_bigmul_unit_v2: table-driven and directed checks of bigmul_unit_v2 with default parameters
module tb_bigmul_unit_v2;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_en = 1'b0;
  logic wr_sel = 1'b0;
  logic [5:0] wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic [6:0] rd_addr = '0;
  logic [63:0] rd_data;
  logic start = 1'b0;
  logic [6:0] n_limbs = '0;
  logic [1:0] mode = '0;
  logic busy, done, err;
  logic [63:0] cycles_out;
  int checks = 0;
  int errors = 0;
  typedef struct {
    string nm;
    logic [63:0] a0, a1, b0, b1;
    logic [6:0] n;
    logic [1:0] m;
    logic [63:0] r0, r1, r2, r3;
    logic [63:0] cyc;
  } vec_t;
  vec_t vt [6];
  bigmul_unit_v2 dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .start(start), .n_limbs(n_limbs), .mode(mode),
    .busy(busy), .done(done), .err(err), .cycles_out(cycles_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic sel, input logic [5:0] addr, input logic [63:0] data);
    wr_en = 1'b1;
    wr_sel = sel;
    wr_addr = addr;
    wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask
  task automatic rd_chk(input string nm, input logic [6:0] addr, input logic [63:0] exp);
    rd_addr = addr;
    tick();
    chk(nm, rd_data, exp);
  endtask
  task automatic wait_done(input string nm, input logic exp_err, input logic [63:0] exp_cyc);
    int t = 0;
    logic seen_busy = 1'b0;
    while (!done && t < 10000) begin
      seen_busy |= busy;
      tick();
      t++;
    end
    chk({nm, " done"}, done, 1'b1);
    chk({nm, " busy_seen"}, seen_busy, !exp_err);
    chk({nm, " busy_at_done"}, busy, 1'b0);
    chk({nm, " err"}, err, exp_err);
    chk({nm, " cycles"}, cycles_out, exp_cyc);
    if (exp_err) chk({nm, " err_latency"}, t, 0);
    tick();
    chk({nm, " done_single"}, done, 1'b0);
  endtask
  task automatic run(input string nm, input logic [6:0] n, input logic [1:0] m, input logic exp_err, input logic [63:0] exp_cyc);
    start = 1'b1;
    n_limbs = n;
    mode = m;
    tick();
    start = 1'b0;
    wait_done(nm, exp_err, exp_cyc);
  endtask
  initial begin
    vt[0] = '{"mul2", 64'h38, 64'h3, 64'h17, 64'h0, 7'd2, 2'b00, 64'h508, 64'h45, 64'h0, 64'h0, 64'd10};
    vt[1] = '{"mul1", ONES, 64'h0, ONES, 64'h0, 7'd1, 2'b00, 64'h1, ONES - 64'd1, 64'h0, 64'h0, 64'd4};
    vt[2] = '{"sq2", ONES, ONES, 64'h5, 64'h5, 7'd2, 2'b01, 64'h1, 64'h0, ONES - 64'd1, ONES, 64'd10};
    vt[3] = '{"mac2", ONES, ONES, ONES, ONES, 7'd2, 2'b10, 64'h2, 64'h0, ONES - 64'd3, ONES, 64'd6};
    vt[4] = '{"mul2b", 64'd5, 64'd7, 64'd11, 64'd13, 7'd2, 2'b00, 64'd55, 64'd142, 64'd91, 64'h0, 64'd10};
    vt[5] = '{"mac1", 64'd2, 64'd7, 64'd3, 64'd13, 7'd1, 2'b10, 64'd61, 64'd142, 64'd91, 64'h0, 64'd2};
    tick();
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset err", err, 1'b0);
    chk("reset rd_data", rd_data, 64'h0);
    chk("reset cycles", cycles_out, 64'h0);
    rst = 1'b0;
    tick();
    for (int v = 0; v < 6; v++) begin
      wr(1'b0, 6'd0, vt[v].a0);
      wr(1'b0, 6'd1, vt[v].a1);
      wr(1'b1, 6'd0, vt[v].b0);
      wr(1'b1, 6'd1, vt[v].b1);
      run(vt[v].nm, vt[v].n, vt[v].m, 1'b0, vt[v].cyc);
      rd_chk({vt[v].nm, " R0"}, 7'd0, vt[v].r0);
      rd_chk({vt[v].nm, " R1"}, 7'd1, vt[v].r1);
      rd_chk({vt[v].nm, " R2"}, 7'd2, vt[v].r2);
      rd_chk({vt[v].nm, " R3"}, 7'd3, vt[v].r3);
    end
    run("ill_n0", 7'd0, 2'b00, 1'b1, 64'd0);
    run("ill_mode3", 7'd2, 2'b11, 1'b1, 64'd0);
    run("ill_n65", 7'd65, 2'b00, 1'b1, 64'd0);
    rd_chk("ill R0", 7'd0, 64'd61);
    rd_chk("ill R1", 7'd1, 64'd142);
    wr(1'b1, 6'd0, 64'h17);
    wr_en = 1'b1;
    wr_sel = 1'b0;
    wr_addr = 6'd0;
    wr_data = 64'd9;
    start = 1'b1;
    n_limbs = 7'd1;
    mode = 2'b00;
    tick();
    wr_en = 1'b0;
    start = 1'b0;
    wait_done("wr_start", 1'b0, 64'd4);
    rd_chk("wr_start R0", 7'd0, 64'hCF);
    rd_chk("wr_start R1", 7'd1, 64'h0);
    wr(1'b0, 6'd0, 64'h38);
    wr(1'b0, 6'd1, 64'h3);
    wr(1'b1, 6'd0, 64'h17);
    wr(1'b1, 6'd1, 64'h0);
    start = 1'b1;
    n_limbs = 7'd4;
    mode = 2'b00;
    tick();
    start = 1'b0;
    tick();
    chk("rst busy before write", busy, 1'b1);
    wr(1'b0, 6'd0, 64'hDEAD);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    chk("midrst busy", busy, 1'b0);
    chk("midrst done", done, 1'b0);
    chk("midrst err", err, 1'b0);
    chk("midrst cycles", cycles_out, 64'h0);
    chk("midrst rd_data", rd_data, 64'h0);
    rst = 1'b0;
    run("rerun", 7'd2, 2'b00, 1'b0, 64'd10);
    rd_chk("rerun R0", 7'd0, 64'h508);
    rd_chk("rerun R1", 7'd1, 64'h45);
    rd_chk("rerun R2", 7'd2, 64'h0);
    rd_chk("rerun R3", 7'd3, 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
